// File: rtl/alu_result_buffer.sv
// alu_result_buffer: ALU execute stage with a 2-entry result FIFO feeding the CDB arbiter.
// Backpressures the reservation station through a conservative execute enable.
module alu_result_buffer #(
    parameter int WIDTH   = 31,
    parameter int ROB     = 2,
    parameter int C_WIDTH = 3
) (
    input  logic                clk,
    input  logic                globalReset,
    input  logic                clear,
    input  logic                validCommit,
    input  logic signed [WIDTH:0] src1,
    input  logic signed [WIDTH:0] src2,
    input  logic [C_WIDTH:0]    instrInfo,
    input  logic [ROB:0]        instrRob,
    input  logic                cdbGrant,
    output logic                execute,
    output logic                cdbRequest,
    output logic [WIDTH:0]      cdbValue,
    output logic [ROB:0]        cdbRob,
    output logic                overflow
);
    logic [WIDTH:0] val_q [2];
    logic [ROB:0]   rob_q [2];
    logic [1:0]     count_q, count_d;
    logic           head_q, head_d, tail_q, tail_d, ovf_q, ovf_d;
    logic           in_valid, flush, full, push, pop;
    logic [WIDTH:0] result;
    logic [4:0]     shamt;
    always_comb begin
        shamt = src2[4:0];
        case (instrInfo)
            4'd0:    result = src1 + src2;
            4'd1:    result = src1 - src2;
            4'd2:    result = src1 & src2;
            4'd3:    result = src1 | src2;
            4'd4:    result = src1 ^ src2;
            4'd5:    result = src1 << shamt;
            4'd6:    result = $unsigned(src1) >> shamt;
            4'd7:    result = src1 >>> shamt;
            4'd8:    result = {{WIDTH{1'b0}}, src1 < src2};
            4'd9:    result = {{WIDTH{1'b0}}, $unsigned(src1) < $unsigned(src2)};
            4'd10:   result = src2;
            default: result = '0;
        endcase
    end
    // execute ignores a same-cycle pop so the selection registered now always finds a slot
    always_comb begin
        in_valid   = instrInfo != '1;
        flush      = clear & validCommit;
        full       = count_q == 2'd2;
        cdbRequest = count_q != 2'd0;
        pop        = cdbRequest & cdbGrant;
        push       = in_valid & ~full & ~flush;
        count_d    = flush ? 2'd0 : 2'(count_q + {1'b0, push} - {1'b0, pop});
        head_d     = flush ? 1'b0 : head_q ^ pop;
        tail_d     = flush ? 1'b0 : tail_q ^ push;
        ovf_d      = ovf_q | (in_valid & full);
        execute    = ~globalReset & ((count_q == 2'd0) | ((count_q == 2'd1) & ~in_valid));
        cdbValue   = cdbRequest ? val_q[head_q] : '0;
        cdbRob     = cdbRequest ? rob_q[head_q] : '0;
        overflow   = ovf_q;
    end
    always_ff @(posedge clk) begin
        if (globalReset) begin
            count_q <= '0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                val_q[i] <= '0;
                rob_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ovf_q   <= ovf_d;
            if (push) begin
                val_q[tail_q] <= result;
                rob_q[tail_q] <= instrRob;
            end
        end
    end
endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Execution stage directly downstream of the ALU reservation station.
- Consumes the registered operands, ALU control code and ROB tag that the station issues each cycle, and computes the ALU result.
- Holds results in a 2-entry FIFO until the common-data-bus arbiter grants broadcast.
- Drives the station's `execute` enable as backpressure, so a selected instruction is never issued into a full buffer.

Parameters:
- WIDTH, 31: MSB index of operand/result (32-bit datapath).
- ROB, 2: MSB index of ROB tag (8 entries).
- C_WIDTH, 3: MSB index of ALU control code.

Ports:
- clk  in  1  rising-edge clock.
- globalReset  in  1  synchronous, active-high reset.
- clear  in  1  mispredict flush request; qualified by validCommit.
- validCommit  in  1  flush qualifier; flush = clear & validCommit.
- src1  in  WIDTH+1  signed operand 1 from station output register.
- src2  in  WIDTH+1  signed operand 2 from station output register.
- instrInfo  in  C_WIDTH+1  ALU control code; 4'b1111 = bubble.
- instrRob  in  ROB+1  ROB tag of the incoming instruction.
- cdbGrant  in  1  arbiter grant for the current head entry.
- execute  out  1  to station: it may register a new selection this cycle.
- cdbRequest  out  1  head entry valid, requesting bus.
- cdbValue  out  WIDTH+1  head result.
- cdbRob  out  ROB+1  head ROB tag.
- overflow  out  1  sticky error: valid input arrived while buffer full.

Behaviour:
- Input is valid when instrInfo != 4'b1111. Bubbles are never written.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount = src2[4:0].
  - 1000 SLT (signed), 1001 SLTU (unsigned): result 32'd1 or 32'd0.
  - 1010 PASS (result = src2, used for LUI).
  - 1011-1110 are valid but produce result 0.
- Arithmetic wraps modulo 2^32; no overflow flag.
- Latency: valid input in cycle N is written at the edge ending N. cdbRequest/cdbValue/cdbRob reflect it in N+1 if the buffer was empty.
- FIFO: 2 entries, head/tail 1-bit pointers, 2-bit count (0..2).
  - Pop when cdbRequest & cdbGrant; head advances.
  - Push and pop in the same cycle are both performed; count unchanged.
- Outputs (no combinational path from inputs):
  - cdbRequest = (count != 0).
  - cdbValue/cdbRob are driven from storage at head.
  - cdbValue/cdbRob read 0 when count == 0.
- execute is combinational: 1 iff (count + inputValid) <= 1.
  - This is conservative and ignores a same-cycle pop, guaranteeing a free slot for the instruction the station registers at this edge.
  - execute is forced 0 in any cycle globalReset is high.
- Full with valid input (protocol violation): input dropped, overflow set; buffer contents unchanged apart from a same-cycle pop.
- Flush (clear & validCommit):
  - count := 0 and pointers := 0 at the edge.
  - Same-cycle input is discarded; a same-cycle grant has no further effect.
  - overflow is unaffected.
- globalReset: count, pointers and storage := 0; overflow := 0. Reset wins over flush and push.
- Reset values: cdbRequest = 0, cdbValue = 0, cdbRob = 0, overflow = 0; execute = 1 from the first cycle after reset.
- Reset mid-operation: all buffered results are lost; no request is asserted the following cycle.

Test Plan:
- Reset, then bubble inputs only -> cdbRequest = 0, execute = 1, cdbValue = 0 for 10 cycles.
- ADD src1 = 5, src2 = -7, rob = 3 in cycle N, cdbGrant = 1 from N+1 -> in N+1: cdbRequest = 1, cdbValue = 32'hFFFFFFFE, cdbRob = 3; cdbRequest = 0 in N+2.
- Opcode sweep with src1 = 32'h80000000, src2 = 1 -> SRA 32'hC0000000, SRL 32'h40000000, SLT 1, SLTU 0, PASS 1, opcode 1100 gives 0.
- Three back-to-back valid inputs (rob 1, 2, 3) with cdbGrant = 0 -> execute = 0 once count + valid = 2; raise grant -> broadcasts rob 1, 2, 3 in order.
- Fill to 2 entries, then assert clear & validCommit with a valid input and grant in the same cycle -> next cycle count = 0, cdbRequest = 0, execute = 1.
- Force a valid input while count = 2 and grant = 0 -> overflow = 1 and stays 1 after flush; globalReset clears it.
